// File: rtl/l2_refill_arbiter.sv
// Shares one L2 refill port between the icache and dcache miss paths, arbitrating
// round-robin and assembling full cache lines from narrower L2 beats.
module l2_refill_arbiter #(
  parameter int ADDRESS_BITS  = 32,
  parameter int BLOCK_WIDTH   = 256,
  parameter int MEM_BUS_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,

  input  logic                     ic_valid_i,
  input  logic [ADDRESS_BITS-1:0]  ic_address_i,
  output logic                     ic_ready_o,
  output logic [BLOCK_WIDTH-1:0]   ic_data_o,

  input  logic                     dc_valid_i,
  input  logic [ADDRESS_BITS-1:0]  dc_address_i,
  output logic                     dc_ready_o,
  output logic [BLOCK_WIDTH-1:0]   dc_data_o,

  output logic                     mem_req_o,
  output logic [ADDRESS_BITS-1:0]  mem_address_o,
  input  logic                     mem_grant_i,
  input  logic                     mem_beat_valid_i,
  input  logic [MEM_BUS_WIDTH-1:0] mem_beat_i,

  output logic                     busy_o
);

  localparam int BEATS  = BLOCK_WIDTH / MEM_BUS_WIDTH;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDRESS_BITS-1:0] LINE_MASK =
    {{(ADDRESS_BITS - OFFSET){1'b1}}, {OFFSET{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_BEATS,
    S_DONE
  } state_t;

  state_t                  state;
  logic                    owner;
  logic                    prio;
  logic [CNT_W-1:0]        cnt;

  logic                    ic_pend;
  logic                    dc_pend;
  logic [ADDRESS_BITS-1:0] ic_addr_q;
  logic [ADDRESS_BITS-1:0] dc_addr_q;

  logic [MEM_BUS_WIDTH-1:0] ic_line [BEATS];
  logic [MEM_BUS_WIDTH-1:0] dc_line [BEATS];

  logic                    ic_cand;
  logic                    dc_cand;
  logic                    ic_win;
  logic                    dc_win;
  logic                    grant;
  logic                    ic_owns;
  logic                    dc_owns;
  logic                    beat_accept;
  logic [ADDRESS_BITS-1:0] raw_addr;
  logic [ADDRESS_BITS-1:0] grant_addr;

  // A live valid competes in IDLE without having been latched first.
  assign ic_cand = ic_pend | ic_valid_i;
  assign dc_cand = dc_pend | dc_valid_i;
  assign ic_win  = ic_cand & (~dc_cand | ~prio);
  assign dc_win  = dc_cand & (~ic_cand | prio);
  assign grant   = (state == S_IDLE) && (ic_cand || dc_cand);

  assign ic_owns = ((state == S_REQ) || (state == S_BEATS)) && !owner;
  assign dc_owns = ((state == S_REQ) || (state == S_BEATS)) && owner;

  assign beat_accept = (state == S_BEATS) && mem_beat_valid_i;

  assign raw_addr   = dc_win ? (dc_pend ? dc_addr_q : dc_address_i)
                             : (ic_pend ? ic_addr_q : ic_address_i);
  assign grant_addr = raw_addr & LINE_MASK;

  // Refill sequencer; every port-facing control output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      prio          <= 1'b0;
      cnt           <= '0;
      mem_req_o     <= 1'b0;
      mem_address_o <= '0;
      busy_o        <= 1'b0;
      ic_ready_o    <= 1'b0;
      dc_ready_o    <= 1'b0;
    end else begin
      ic_ready_o <= 1'b0;
      dc_ready_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant) begin
            owner         <= dc_win;
            mem_address_o <= grant_addr;
            mem_req_o     <= 1'b1;
            busy_o        <= 1'b1;
            state         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_grant_i) begin
            mem_req_o <= 1'b0;
            state     <= S_BEATS;
          end
        end
        S_BEATS: begin
          if (mem_beat_valid_i) begin
            if (cnt == LAST_BEAT) begin
              cnt        <= '0;
              state      <= S_DONE;
              ic_ready_o <= ~owner;
              dc_ready_o <= owner;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          prio   <= ~owner;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Pending capture; the owner may re-request during DONE, but not while in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_pend   <= 1'b0;
      dc_pend   <= 1'b0;
      ic_addr_q <= '0;
      dc_addr_q <= '0;
    end else begin
      if (grant && ic_win) begin
        ic_pend <= 1'b0;
      end else if (ic_valid_i && !ic_pend && !ic_owns) begin
        ic_pend   <= 1'b1;
        ic_addr_q <= ic_address_i;
      end

      if (grant && dc_win) begin
        dc_pend <= 1'b0;
      end else if (dc_valid_i && !dc_pend && !dc_owns) begin
        dc_pend   <= 1'b1;
        dc_addr_q <= dc_address_i;
      end
    end
  end

  // Beats land only in the owner's buffer, so the other cache's line stays intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BEATS; i++) begin
        ic_line[i] <= '0;
        dc_line[i] <= '0;
      end
    end else if (beat_accept) begin
      if (owner) begin
        dc_line[cnt] <= mem_beat_i;
      end else begin
        ic_line[cnt] <= mem_beat_i;
      end
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_pack
    assign ic_data_o[g*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] = ic_line[g];
    assign dc_data_o[g*MEM_BUS_WIDTH +: MEM_BUS_WIDTH] = dc_line[g];
  end

endmodule

// File: tb/tb_l2_refill_arbiter.sv
// Directed bench for l2_refill_arbiter: one task per scenario, each with inline
// comparisons against hand-computed lines, addresses and cycle numbers.
module tb_l2_refill_arbiter;

  logic         clk;
  logic         rst_n;
  logic         ic_valid_i;
  logic [31:0]  ic_address_i;
  logic         ic_ready_o;
  logic [255:0] ic_data_o;
  logic         dc_valid_i;
  logic [31:0]  dc_address_i;
  logic         dc_ready_o;
  logic [255:0] dc_data_o;
  logic         mem_req_o;
  logic [31:0]  mem_address_o;
  logic         mem_grant_i;
  logic         mem_beat_valid_i;
  logic [63:0]  mem_beat_i;
  logic         busy_o;

  int checks;
  int errors;
  int cyc;
  int c0;
  int ic_pulses;
  int dc_pulses;
  int last_ic_cyc;
  int last_dc_cyc;

  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_B = {64'hBBBB_0004_0000_0004, 64'hBBBB_0003_0000_0003,
                                     64'hBBBB_0002_0000_0002, 64'hBBBB_0001_0000_0001};
  localparam logic [255:0] LINE_C = {64'hC0DE_0000_0000_00C4, 64'hC0DE_0000_0000_00C3,
                                     64'hC0DE_0000_0000_00C2, 64'hC0DE_0000_0000_00C1};
  localparam logic [255:0] LINE_D = {64'hD00D_FEED_0000_0004, 64'hD00D_FEED_0000_0003,
                                     64'hD00D_FEED_0000_0002, 64'hD00D_FEED_0000_0001};
  localparam logic [63:0]  JUNK   = 64'hDEAD_BEEF_DEAD_BEEF;

  l2_refill_arbiter #(
    .ADDRESS_BITS (32),
    .BLOCK_WIDTH  (256),
    .MEM_BUS_WIDTH(64)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ic_valid_i      (ic_valid_i),
    .ic_address_i    (ic_address_i),
    .ic_ready_o      (ic_ready_o),
    .ic_data_o       (ic_data_o),
    .dc_valid_i      (dc_valid_i),
    .dc_address_i    (dc_address_i),
    .dc_ready_o      (dc_ready_o),
    .dc_data_o       (dc_data_o),
    .mem_req_o       (mem_req_o),
    .mem_address_o   (mem_address_o),
    .mem_grant_i     (mem_grant_i),
    .mem_beat_valid_i(mem_beat_valid_i),
    .mem_beat_i      (mem_beat_i),
    .busy_o          (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle and sample just after the edge; ready pulses are tallied here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (ic_ready_o === 1'b1) begin
      ic_pulses++;
      last_ic_cyc = cyc;
    end
    if (dc_ready_o === 1'b1) begin
      dc_pulses++;
      last_dc_cyc = cyc;
    end
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    ic_valid_i       = 1'b0;
    ic_address_i     = '0;
    dc_valid_i       = 1'b0;
    dc_address_i     = '0;
    mem_grant_i      = 1'b0;
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n       = 1'b1;
    ic_pulses   = 0;
    dc_pulses   = 0;
    last_ic_cyc = -1;
    last_dc_cyc = -1;
    c0          = cyc;
  endtask

  // L2 stand-in: waits (bounded) for a request, grants after a delay, streams 4 beats.
  task automatic serve(input int grant_delay, input logic [255:0] line,
                       output logic [31:0] addr_seen, output bit ok);
    int n;
    logic [255:0] sh;
    ok        = 1'b0;
    addr_seen = '0;
    n         = 0;
    while (mem_req_o !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (mem_req_o !== 1'b1) return;
    addr_seen = mem_address_o;
    repeat (grant_delay) tick();
    mem_grant_i = 1'b1;
    tick();
    mem_grant_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sh               = line >> (64 * b);
      mem_beat_valid_i = 1'b1;
      mem_beat_i       = sh[63:0];
      tick();
    end
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    ok               = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (ic_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ic_ready: got %b expected 0", ic_ready_o); end
    checks++; if (dc_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_dc_ready: got %b expected 0", dc_ready_o); end
    checks++; if (mem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (mem_address_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_address: got %h expected 0", mem_address_o); end
    checks++; if (ic_data_o !== 256'h0) begin errors++; $display("[TB] FAIL reset_ic_data: got %h expected 0", ic_data_o); end
    checks++; if (dc_data_o !== 256'h0) begin errors++; $display("[TB] FAIL reset_dc_data: got %h expected 0", dc_data_o); end
  endtask

  task automatic test_single_ic();
    logic [31:0] a;
    bit ok;
    do_reset();
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_1234;
    tick();
    ic_valid_i = 1'b0;
    serve(0, LINE_A, a, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_req_seen: got %b expected 1", ok); end
    checks++; if (a !== 32'h0000_1220) begin errors++; $display("[TB] FAIL single_mem_address: got %h expected 00001220", a); end
    checks++; if (ic_ready_o !== 1'b1 || cyc - c0 != 6) begin errors++; $display("[TB] FAIL single_ready_cycle: got ready=%b at cycle %0d expected 1 at 6", ic_ready_o, cyc - c0); end
    checks++; if (ic_data_o !== LINE_A) begin errors++; $display("[TB] FAIL single_ic_data: got %h expected %h", ic_data_o, LINE_A); end
    tick();
    checks++; if (ic_ready_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL single_after_done: got ready=%b busy=%b expected 0 0", ic_ready_o, busy_o); end
    checks++; if (ic_data_o !== LINE_A) begin errors++; $display("[TB] FAIL single_data_held: got %h expected %h", ic_data_o, LINE_A); end
    checks++; if (ic_pulses != 1 || dc_pulses != 0) begin errors++; $display("[TB] FAIL single_pulse_count: got ic=%0d dc=%0d expected 1 0", ic_pulses, dc_pulses); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] a;
    bit ok;
    do_reset();
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_2010;
    dc_valid_i   = 1'b1;
    dc_address_i = 32'h0000_3FF8;
    tick();
    ic_valid_i = 1'b0;
    dc_valid_i = 1'b0;
    serve(0, LINE_A, a, ok);
    checks++; if (a !== 32'h0000_2000 || ok !== 1'b1) begin errors++; $display("[TB] FAIL simul_first_address: got %h ok=%b expected 00002000 ok=1", a, ok); end
    checks++; if (ic_ready_o !== 1'b1 || dc_ready_o !== 1'b0 || cyc - c0 != 6) begin errors++; $display("[TB] FAIL simul_ic_first: got ic=%b dc=%b at cycle %0d expected 1 0 at 6", ic_ready_o, dc_ready_o, cyc - c0); end
    serve(0, LINE_B, a, ok);
    checks++; if (a !== 32'h0000_3FE0 || ok !== 1'b1) begin errors++; $display("[TB] FAIL simul_dc_address: got %h ok=%b expected 00003fe0 ok=1", a, ok); end
    checks++; if (dc_ready_o !== 1'b1 || cyc - c0 != 13) begin errors++; $display("[TB] FAIL simul_dc_ready_cycle: got ready=%b at cycle %0d expected 1 at 13", dc_ready_o, cyc - c0); end
    checks++; if (dc_data_o !== LINE_B) begin errors++; $display("[TB] FAIL simul_dc_data: got %h expected %h", dc_data_o, LINE_B); end
    checks++; if (ic_data_o !== LINE_A) begin errors++; $display("[TB] FAIL simul_ic_undisturbed: got %h expected %h", ic_data_o, LINE_A); end
  endtask

  task automatic test_round_robin();
    logic [31:0] a;
    logic [31:0] exp_a;
    logic [3:0]  owners;
    bit ok;
    bit all_ok;
    do_reset();
    owners       = '0;
    all_ok       = 1'b1;
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_0100;
    dc_valid_i   = 1'b1;
    dc_address_i = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      serve(0, LINE_C, a, ok);
      owners[k] = dc_ready_o;
      exp_a     = k[0] ? 32'h0000_0200 : 32'h0000_0100;
      if (ok !== 1'b1 || a !== exp_a) all_ok = 1'b0;
    end
    ic_valid_i = 1'b0;
    dc_valid_i = 1'b0;
    checks++; if (owners !== 4'b1010) begin errors++; $display("[TB] FAIL rr_grant_order: got %b expected 1010 (bit0 first)", owners); end
    checks++; if (all_ok !== 1'b1) begin errors++; $display("[TB] FAIL rr_addresses: got mismatch flag %b expected 1", all_ok); end
    checks++; if (ic_pulses != 2 || dc_pulses != 2) begin errors++; $display("[TB] FAIL rr_pulse_counts: got ic=%0d dc=%0d expected 2 2", ic_pulses, dc_pulses); end
  endtask

  task automatic test_stalls();
    int reqcnt;
    int bi;
    int pat [7];
    logic [255:0] sh;
    do_reset();
    pat          = '{1, 0, 0, 1, 1, 0, 1};
    reqcnt       = 0;
    bi           = 0;
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_ABCD;
    tick();
    ic_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req_o === 1'b1) reqcnt++;
      tick();
    end
    if (mem_req_o === 1'b1) reqcnt++;
    mem_grant_i = 1'b1;
    tick();
    mem_grant_i = 1'b0;
    if (mem_req_o === 1'b1) reqcnt++;
    checks++; if (reqcnt != 4) begin errors++; $display("[TB] FAIL stall_req_cycles: got %0d expected 4", reqcnt); end
    checks++; if (mem_address_o !== 32'h0000_ABC0) begin errors++; $display("[TB] FAIL stall_mem_address: got %h expected 0000abc0", mem_address_o); end
    for (int i = 0; i < 7; i++) begin
      if (pat[i] == 1) begin
        sh               = LINE_D >> (64 * bi);
        mem_beat_valid_i = 1'b1;
        mem_beat_i       = sh[63:0];
        bi++;
      end else begin
        mem_beat_valid_i = 1'b0;
        mem_beat_i       = JUNK;
      end
      tick();
    end
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    checks++; if (ic_ready_o !== 1'b1 || cyc - c0 != 12) begin errors++; $display("[TB] FAIL stall_ready_cycle: got ready=%b at cycle %0d expected 1 at 12", ic_ready_o, cyc - c0); end
    checks++; if (ic_data_o !== LINE_D) begin errors++; $display("[TB] FAIL stall_line: got %h expected %h", ic_data_o, LINE_D); end
    tick();
    tick();
    checks++; if (ic_pulses != 1 || busy_o !== 1'b0) begin errors++; $display("[TB] FAIL stall_single_pulse: got pulses=%0d busy=%b expected 1 0", ic_pulses, busy_o); end
  endtask

  task automatic test_ignored();
    logic [31:0] a;
    bit ok;
    do_reset();
    ic_valid_i       = 1'b1;
    ic_address_i     = 32'h1000_0047;
    dc_valid_i       = 1'b1;
    dc_address_i     = 32'h2000_0085;
    mem_beat_valid_i = 1'b1;
    mem_beat_i       = JUNK;
    tick();
    ic_valid_i   = 1'b0;
    dc_valid_i   = 1'b1;
    dc_address_i = 32'h3000_00C3;
    checks++; if (mem_req_o !== 1'b1 || mem_address_o !== 32'h1000_0040) begin errors++; $display("[TB] FAIL ign_first_req: got req=%b addr=%h expected 1 10000040", mem_req_o, mem_address_o); end
    tick();
    dc_valid_i       = 1'b0;
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    checks++; if (mem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL ign_still_req: got %b expected 1", mem_req_o); end
    serve(0, LINE_A, a, ok);
    checks++; if (ic_ready_o !== 1'b1 || ic_data_o !== LINE_A) begin errors++; $display("[TB] FAIL ign_ic_line: got ready=%b data=%h expected 1 %h", ic_ready_o, ic_data_o, LINE_A); end
    serve(0, LINE_B, a, ok);
    checks++; if (a !== 32'h2000_0080 || ok !== 1'b1) begin errors++; $display("[TB] FAIL ign_dc_first_address: got %h ok=%b expected 20000080 ok=1", a, ok); end
    checks++; if (dc_ready_o !== 1'b1 || dc_data_o !== LINE_B) begin errors++; $display("[TB] FAIL ign_dc_line: got ready=%b data=%h expected 1 %h", dc_ready_o, dc_data_o, LINE_B); end
  endtask

  task automatic test_reset_mid_beats();
    logic [31:0] a;
    bit ok;
    do_reset();
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_5555;
    tick();
    ic_valid_i  = 1'b0;
    mem_grant_i = 1'b1;
    tick();
    mem_grant_i      = 1'b0;
    mem_beat_valid_i = 1'b1;
    mem_beat_i       = LINE_A[63:0];
    tick();
    mem_beat_i = LINE_A[127:64];
    tick();
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", busy_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || mem_req_o !== 1'b0 || ic_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_controls: got busy=%b req=%b ready=%b expected 0 0 0", busy_o, mem_req_o, ic_ready_o); end
    checks++; if (ic_data_o !== 256'h0 || mem_address_o !== 32'h0) begin errors++; $display("[TB] FAIL midrst_data: got data=%h addr=%h expected 0 0", ic_data_o, mem_address_o); end
    do_reset();
    ic_valid_i   = 1'b1;
    ic_address_i = 32'h0000_6000;
    tick();
    ic_valid_i = 1'b0;
    serve(0, LINE_B, a, ok);
    checks++; if (ic_ready_o !== 1'b1 || cyc - c0 != 6 || a !== 32'h0000_6000) begin errors++; $display("[TB] FAIL midrst_new_refill: got ready=%b cycle=%0d addr=%h expected 1 6 00006000", ic_ready_o, cyc - c0, a); end
    checks++; if (ic_data_o !== LINE_B) begin errors++; $display("[TB] FAIL midrst_new_line: got %h expected %h", ic_data_o, LINE_B); end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    cyc              = 0;
    c0               = 0;
    ic_pulses        = 0;
    dc_pulses        = 0;
    last_ic_cyc      = -1;
    last_dc_cyc      = -1;
    rst_n            = 1'b0;
    ic_valid_i       = 1'b0;
    ic_address_i     = '0;
    dc_valid_i       = 1'b0;
    dc_address_i     = '0;
    mem_grant_i      = 1'b0;
    mem_beat_valid_i = 1'b0;
    mem_beat_i       = '0;
    $display("[TB] starting l2_refill_arbiter bench");
    test_reset();
    test_single_ic();
    test_simultaneous();
    test_round_robin();
    test_stalls();
    test_ignored();
    test_reset_mid_beats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
